ifmap_skew_buffer: RTL and testbench

- Sits directly downstream of the ifmap address/read-enable controller and the ifmap SRAM. Feeds the ifmap edge of the MAC_ROW x MAC_COL systolic array.
- Aligns SRAM read data to the read-enable timing, then staggers it: row lane r is delayed r extra cycles, giving the diagonal wavefront the array needs.
- Tracks burst state and pulses a done flag when the last lane has drained.
- Flags protocol errors: data arriving without a preceding start.

---
 rtl/ifmap_skew_buffer_pkg.sv | 16 +
 rtl/ifmap_skew_buffer_if.sv | 33 +++
 rtl/ifmap_skew_buffer_skew_lane_delay.sv | 49 ++++
 rtl/ifmap_skew_buffer.sv | 141 ++++++++++++++
 tb/tb_ifmap_skew_buffer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ifmap_skew_buffer_pkg.sv
// Shared types and defaults for the ifmap skew buffer: lane width,
// FSM state encoding and the default SRAM read latency.
package ifmap_skew_buffer_pkg;

  localparam int MAC_ROW_DEF           = 16;
  localparam int IFMAP_BITWIDTH_DEF    = 16;
  localparam int IFMAP_LANE_W          = IFMAP_BITWIDTH_DEF;
  localparam int SRAM_READ_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skewState_e;

endpackage

// File: rtl/ifmap_skew_buffer_if.sv
// Bus between the ifmap controller / SRAM side and the skew buffer, plus
// the skewed array-facing outputs. The master side drives the controller
// signals and observes the array-facing ones; the skew buffer is the slave.
interface ifmap_skew_buffer_if
  import ifmap_skew_buffer_pkg::*;
#(
  parameter int MAC_ROW        = MAC_ROW_DEF,
  parameter int IFMAP_BITWIDTH = IFMAP_LANE_W
);

  logic                              ifmap_start_in;
  logic                              ifmap_read_en_in;
  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_rdata_in;
  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] mac_ifmap_data_out;
  logic [MAC_ROW-1:0]                mac_ifmap_valid_out;
  logic                              mac_start_out;
  logic                              skew_busy;
  logic                              skew_done;
  logic                              proto_err;

  modport master (
    output ifmap_start_in, ifmap_read_en_in, ifmap_rdata_in,
    input  mac_ifmap_data_out, mac_ifmap_valid_out, mac_start_out,
           skew_busy, skew_done, proto_err
  );

  modport slave (
    input  ifmap_start_in, ifmap_read_en_in, ifmap_rdata_in,
    output mac_ifmap_data_out, mac_ifmap_valid_out, mac_start_out,
           skew_busy, skew_done, proto_err
  );

endinterface

// File: rtl/ifmap_skew_buffer_skew_lane_delay.sv
// One ifmap lane: a free-running shift chain of DEPTH registers carrying
// data plus valid. The first stage captures data only on valid beats.
// With IFMAP_SKEW_ZERO_GATE_EN defined the data output reads 0 whenever
// the output valid is low; otherwise it shows whatever the last stage holds.
module skew_lane_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             occupied_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Shift data and valid one stage per cycle; reset empties the whole chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o    = valid_q[DEPTH-1];
  assign occupied_o = |valid_q;

`ifdef IFMAP_SKEW_ZERO_GATE_EN
  assign data_o = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
`else
  assign data_o = data_q[DEPTH-1];
`endif

endmodule

// File: rtl/ifmap_skew_buffer.sv
// Ifmap skew buffer: realigns SRAM read data to the read-enable timing,
// then delays lane r by r extra cycles to form the diagonal wavefront the
// systolic array consumes. Tracks burst state, pulses done after the last
// lane drains, and flags data that arrives without a start.
// Optional macro: IFMAP_SKEW_ZERO_GATE_EN (zero data on invalid lanes).
module ifmap_skew_buffer
  import ifmap_skew_buffer_pkg::*;
#(
  parameter int MAC_ROW           = MAC_ROW_DEF,
  parameter int IFMAP_BITWIDTH    = IFMAP_LANE_W,
  parameter int SRAM_READ_LATENCY = SRAM_READ_LATENCY_DEF
) (
  input logic             clk,
  input logic             rstn,
  ifmap_skew_buffer_if.slave bus
);

  logic [SRAM_READ_LATENCY-1:0] readEnPipe_q;
  logic [SRAM_READ_LATENCY-1:0] startPipe_q;
  logic                         inValid;
  logic                         startD;

  logic [IFMAP_BITWIDTH-1:0]    laneData [MAC_ROW];
  logic [MAC_ROW-1:0]           laneValid;
  logic [MAC_ROW-1:0]           laneOccupied;
  logic                         chainsBusy;

  skewState_e                   state_q, state_d;
  logic                         sawValid_q, sawValid_d;
  logic                         err_q;
  logic                         errNow;
  logic                         macStart_q;
  logic                         done;

  // Delay read enable and start by the SRAM read latency so they line up
  // with the data the SRAM returns
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      readEnPipe_q <= '0;
      startPipe_q  <= '0;
    end else begin
      readEnPipe_q[0] <= bus.ifmap_read_en_in;
      startPipe_q[0]  <= bus.ifmap_start_in;
      for (int i = 1; i < SRAM_READ_LATENCY; i++) begin
        readEnPipe_q[i] <= readEnPipe_q[i-1];
        startPipe_q[i]  <= startPipe_q[i-1];
      end
    end
  end

  assign inValid = readEnPipe_q[SRAM_READ_LATENCY-1];
  assign startD  = startPipe_q[SRAM_READ_LATENCY-1];

  // Lane r gets r+1 register stages, producing the diagonal skew
  for (genvar r = 0; r < MAC_ROW; r++) begin : gLane
    skew_lane_delay #(
      .DEPTH(r + 1),
      .WIDTH(IFMAP_BITWIDTH)
    ) uLane (
      .clk       (clk),
      .rstn      (rstn),
      .data_i    (bus.ifmap_rdata_in[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]),
      .valid_i   (inValid),
      .data_o    (laneData[r]),
      .valid_o   (laneValid[r]),
      .occupied_o(laneOccupied[r])
    );
  end

  assign chainsBusy = |laneOccupied;

  // Repack the per-lane outputs onto the array-facing bus
  always_comb begin
    bus.mac_ifmap_data_out = '0;
    for (int r = 0; r < MAC_ROW; r++) begin
      bus.mac_ifmap_data_out[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] = laneData[r];
    end
  end

  assign bus.mac_ifmap_valid_out = laneValid;

  // Burst tracking: a start in DRAIN folds the new burst into the old one,
  // so done only fires once the merged burst has fully left the chains
  always_comb begin
    state_d    = state_q;
    sawValid_d = sawValid_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ifmap_start_in) begin
          state_d    = STREAM;
          sawValid_d = 1'b0;
        end
      end
      STREAM: begin
        if (inValid) begin
          sawValid_d = 1'b1;
        end else if (sawValid_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.ifmap_start_in) begin
          state_d    = STREAM;
          sawValid_d = 1'b0;
        end else if (!inValid && !chainsBusy) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, start alignment and sticky error registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sawValid_q <= 1'b0;
      err_q      <= 1'b0;
      macStart_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sawValid_q <= sawValid_d;
      err_q      <= err_q | errNow;
      macStart_q <= startD;
    end
  end

  // Data showing up in IDLE without its start is a controller protocol
  // error; flag it in the same cycle and hold it until reset
  assign errNow        = inValid && (state_q == IDLE) && !startD;
  assign bus.proto_err = err_q | errNow;

  assign bus.mac_start_out = macStart_q;
  assign bus.skew_busy     = (state_q != IDLE);
  assign bus.skew_done     = done;

endmodule

// File: tb/tb_ifmap_skew_buffer.sv
// Scoreboard bench for ifmap_skew_buffer (MAC_ROW=16, latency 1).
// Each driven read enable pushes one expected beat per lane, stamped with
// the cycle it must appear; the monitor pops and compares every cycle.
module tb_ifmap_skew_buffer;

  localparam int MAC_ROW = 16;
  localparam int W       = 16;
  localparam int LAT     = 1;

  typedef struct {
    int          cyc;
    logic [W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  ifmap_skew_buffer_if #(.MAC_ROW(MAC_ROW), .IFMAP_BITWIDTH(W)) bus ();

  ifmap_skew_buffer #(
    .MAC_ROW          (MAC_ROW),
    .IFMAP_BITWIDTH   (W),
    .SRAM_READ_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  beat_t laneQ [MAC_ROW][$];
  int    startQ[$];
  int    doneQ[$];
  int    cyc = 0;
  int    nCompared = 0;
  int    nMismatched = 0;
  int    busyLo = -1;
  int    busyHi = -2;
  int    errFrom = -1;
  logic  prevEn = 1'b0;
  logic [7:0] prevTag = 8'd0;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard for the current cycle
  task automatic monitor();
    logic expV;
    logic expS;
    logic expD;
    for (int r = 0; r < MAC_ROW; r++) begin
      expV = (laneQ[r].size() > 0) && (laneQ[r][0].cyc == cyc);
      checkOutput($sformatf("valid[%0d]", r), 32'(bus.mac_ifmap_valid_out[r]), 32'(expV));
      if (expV) begin
        checkOutput($sformatf("data[%0d]", r), 32'(bus.mac_ifmap_data_out[r*W +: W]), 32'(laneQ[r][0].data));
        void'(laneQ[r].pop_front());
      end
`ifdef IFMAP_SKEW_ZERO_GATE_EN
      else begin
        checkOutput($sformatf("zerogate[%0d]", r), 32'(bus.mac_ifmap_data_out[r*W +: W]), 32'd0);
      end
`endif
    end
    expS = (startQ.size() > 0) && (startQ[0] == cyc);
    if (expS) void'(startQ.pop_front());
    checkOutput("mac_start", 32'(bus.mac_start_out), 32'(expS));
    expD = (doneQ.size() > 0) && (doneQ[0] == cyc);
    if (expD) void'(doneQ.pop_front());
    checkOutput("skew_done", 32'(bus.skew_done), 32'(expD));
    checkOutput("skew_busy", 32'(bus.skew_busy), 32'((cyc >= busyLo) && (cyc <= busyHi)));
    checkOutput("proto_err", 32'(bus.proto_err), 32'((errFrom >= 0) && (cyc >= errFrom)));
  endtask

  // Advance one cycle, check outputs, then drive this cycle's inputs.
  // The SRAM model returns lane r = tag + 256*r one cycle after a read.
  task automatic applyStimulus(input logic start, input logic en, input logic [7:0] tag);
    beat_t b;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    bus.ifmap_start_in   = start;
    bus.ifmap_read_en_in = en;
    for (int r = 0; r < MAC_ROW; r++) begin
      if (prevEn) bus.ifmap_rdata_in[r*W +: W] = {r[7:0], prevTag};
      else        bus.ifmap_rdata_in[r*W +: W] = W'($urandom);
    end
    prevEn  = en;
    prevTag = tag;
    if (en) begin
      for (int r = 0; r < MAC_ROW; r++) begin
        b.cyc  = cyc + LAT + 1 + r;
        b.data = {r[7:0], tag};
        laneQ[r].push_back(b);
      end
    end
    if (start) startQ.push_back(cyc + LAT + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  // 14-beat burst with start on the first read enable
  task automatic burst14();
    int t;
    applyStimulus(1'b1, 1'b1, 8'd0);
    t = cyc;
    doneQ.push_back(t + 31);
    busyLo = t + 1;
    busyHi = t + 31;
    for (int i = 1; i < 14; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    idle(25);
  endtask

  initial begin
    int t;
    bus.ifmap_start_in   = 1'b0;
    bus.ifmap_read_en_in = 1'b0;
    bus.ifmap_rdata_in   = '0;

    $display("[TB] reset state");
    idle(3);
    rstn = 1'b1;
    idle(3);

    $display("[TB] single 14-beat burst");
    burst14();

    $display("[TB] single-beat burst");
    applyStimulus(1'b1, 1'b1, 8'h55);
    t = cyc;
    doneQ.push_back(t + 18);
    busyLo = t + 1;
    busyHi = t + 18;
    idle(25);

    $display("[TB] back-to-back bursts merged in drain");
    applyStimulus(1'b1, 1'b1, 8'd0);
    t = cyc;
    doneQ.push_back(t + 42);
    busyLo = t + 1;
    busyHi = t + 42;
    for (int i = 1; i < 14; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    idle(6);
    applyStimulus(1'b1, 1'b1, 8'h20);
    for (int i = 1; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h20 + i));
    idle(30);

    $display("[TB] read enable without start");
    applyStimulus(1'b0, 1'b1, 8'h77);
    errFrom = cyc + 1;
    idle(25);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b1, 8'd0);
    t = cyc;
    doneQ.push_back(t + 31);
    busyLo = t + 1;
    busyHi = t + 31;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.mac_ifmap_valid_out), 32'd0);
    checkOutput("rst_data_lo", bus.mac_ifmap_data_out[31:0], 32'd0);
    checkOutput("rst_data_hi", bus.mac_ifmap_data_out[255:224], 32'd0);
    checkOutput("rst_busy", 32'(bus.skew_busy), 32'd0);
    checkOutput("rst_err", 32'(bus.proto_err), 32'd0);
    checkOutput("rst_done", 32'(bus.skew_done), 32'd0);
    checkOutput("rst_start", 32'(bus.mac_start_out), 32'd0);
    for (int r = 0; r < MAC_ROW; r++) laneQ[r].delete();
    startQ.delete();
    doneQ.delete();
    busyHi  = -2;
    errFrom = -1;
    prevEn  = 1'b0;
    bus.ifmap_start_in   = 1'b0;
    bus.ifmap_read_en_in = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);
    burst14();

    $display("[TB] bubble in every lane");
    applyStimulus(1'b1, 1'b1, 8'd0);
    t = cyc;
    doneQ.push_back(t + 27);
    busyLo = t + 1;
    busyHi = t + 27;
    for (int i = 1; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    applyStimulus(1'b0, 1'b0, 8'd0);
    for (int i = 5; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    idle(25);

    for (int r = 0; r < MAC_ROW; r++) begin
      checkOutput($sformatf("leftover[%0d]", r), 32'(laneQ[r].size()), 32'd0);
    end
    checkOutput("leftover_done", 32'(doneQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
